// File: rtl/risc_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : risc_mem_pkg                                                    |
// | Purpose  : Shared defaults and store-buffer entry type for the data-memory |
// |            stage behind RISC_Processor.                                    |
// | Contents : DEF_ADDR_W, DEF_DATA_W, DEF_SB_DEPTH, CORE_ADDR_W, sb_entry_t   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package risc_mem_pkg;

  localparam int DEF_ADDR_W   = 8;    // RAM word-address width
  localparam int DEF_DATA_W   = 128;  // RAM word width
  localparam int DEF_SB_DEPTH = 4;    // store-buffer entries (power of two)
  localparam int CORE_ADDR_W  = 16;   // address width presented by the core

  // One store-buffer slot. Fields are sized for the default geometry; the top
  // level narrows/widens into them with explicit casts.
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_ram                                                        |
// | Purpose  : Single-port synchronous data RAM, registered read, written for  |
// |            block-RAM inference. Contents are never reset.                  |
// | Ports    : clk            - rising-edge clock                              |
// |            we             - write enable (wdata -> mem[addr])              |
// |            re             - read enable (mem[addr] -> rdata next edge)     |
// |            addr [ADDR_W]  - shared read/write word address                 |
// |            wdata/rdata    - write data / registered read data              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_ram
  import risc_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // rdata only moves on a read, so it holds the last load result while the
  // port is used for drains or sits idle.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= r_mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_store_buffer                                               |
// | Purpose  : Data-memory stage: single-port RAM behind a FIFO store buffer   |
// |            with youngest-match load forwarding. Loads own the RAM port;    |
// |            the buffer drains on idle cycles and forcibly when full.        |
// | Ports    : clk, reset (sync, active-high)                                  |
// |            Address[16]  - word address (low ADDR_W bits used, aliasing)    |
// |            Alu_Out      - store data                                       |
// |            mw_en/mr_en  - store / load request (store wins)                |
// |            D_in         - load data, 1-cycle latency                       |
// |            d_valid      - D_in carries the previous cycle's accepted load  |
// |            stall        - load not accepted this cycle (buffer full)       |
// |            sb_count     - occupied entries; sb_full - sb_count==SB_DEPTH   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_store_buffer
  import risc_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CORE_ADDR_W-1:0]      Address,
  input  logic [DATA_W-1:0]           Alu_Out,
  input  logic                        mw_en,
  input  logic                        mr_en,
  output logic [DATA_W-1:0]           D_in,
  output logic                        d_valid,
  output logic                        stall,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_full
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t           r_sb [SB_DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                r_full;
  logic                r_d_valid;
  logic                r_fwd_hit;
  logic [DATA_W-1:0]   r_fwd_data;

  logic                w_is_store;
  logic                w_is_load;
  logic                w_is_idle;
  logic                w_drain;
  logic                w_load_acc;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [DATA_W-1:0]   w_ram_q;
  logic                w_fwd_hit;
  logic [DATA_W-1:0]   w_fwd_data;
  logic                w_addr_unused;

  // Upper core-address bits alias onto the RAM; they are deliberately dropped.
  assign w_addr_unused = ^Address[CORE_ADDR_W-1:ADDR_W];
  assign w_req_addr    = Address[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Request classification and port arbitration
  // ---------------------------------------------------------------------------
  assign w_is_store = mw_en;
  assign w_is_load  = mr_en & ~mw_en;
  assign w_is_idle  = ~mr_en & ~mw_en;

  // Stores only force a drain when the buffer is full, so back-to-back stores
  // accumulate; a full-buffer store pushes and pops together and never stalls.
  assign w_drain    = (r_count != '0) & (w_is_idle | r_full);
  assign w_load_acc = w_is_load & ~r_full;
  assign stall      = w_is_load & r_full;

  assign w_count_nxt = r_count + CNT_W'(w_is_store) - CNT_W'(w_drain);

  assign w_ram_addr  = w_drain ? r_sb[r_head].addr[ADDR_W-1:0] : w_req_addr;
  assign w_ram_wdata = r_sb[r_head].data[DATA_W-1:0];

  dmem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_drain & ~reset),
    .re    (w_load_acc & ~reset),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_q)
  );

  // ---------------------------------------------------------------------------
  // Forwarding: walk oldest to youngest so the last match wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = r_head + PTR_W'(i);
      if (r_sb[idx].valid && (r_sb[idx].addr[ADDR_W-1:0] == w_req_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_sb[idx].data[DATA_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer state and load result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_sb[i].valid <= 1'b0;
      end
      r_d_valid  <= 1'b0;
      // Selecting the (zeroed) forward register makes D_in read 0 after reset
      // without needing a reset on the RAM output register.
      r_fwd_hit  <= 1'b1;
      r_fwd_data <= '0;
    end else begin
      // Pop before push: when full, head==tail and the push must win.
      if (w_drain) begin
        r_sb[r_head].valid <= 1'b0;
        r_head             <= r_head + PTR_W'(1);
      end
      if (w_is_store) begin
        r_sb[r_tail] <= '{valid: 1'b1,
                          addr:  DEF_ADDR_W'(w_req_addr),
                          data:  DEF_DATA_W'(Alu_Out)};
        r_tail       <= r_tail + PTR_W'(1);
      end
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == CNT_W'(SB_DEPTH));
      r_d_valid <= w_load_acc;
      if (w_load_acc) begin
        r_fwd_hit  <= w_fwd_hit;
        r_fwd_data <= w_fwd_data;
      end
    end
  end

  assign D_in     = r_fwd_hit ? r_fwd_data : w_ram_q;
  assign d_valid  = r_d_valid;
  assign sb_count = r_count;
  assign sb_full  = r_full;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_store_buffer                                            |
// | Purpose  : Scoreboard bench for dmem_store_buffer. A driver issues one     |
// |            request per cycle and updates a queue/array reference model;    |
// |            accepted loads push their expected data, and a monitor pops and |
// |            compares whenever the DUT reports d_valid.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dmem_store_buffer;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 128;
  localparam int SB_DEPTH = 4;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic [15:0]       Address = '0;
  logic [DATA_W-1:0] Alu_Out = '0;
  logic              mw_en   = 1'b0;
  logic              mr_en   = 1'b0;
  logic [DATA_W-1:0] D_in;
  logic              d_valid;
  logic              stall;
  logic [2:0]        sb_count;
  logic              sb_full;

  dmem_store_buffer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SB_DEPTH (SB_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .Alu_Out  (Alu_Out),
    .mw_en    (mw_en),
    .mr_en    (mr_en),
    .D_in     (D_in),
    .d_valid  (d_valid),
    .stall    (stall),
    .sb_count (sb_count),
    .sb_full  (sb_full)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: pending stores as an ordered queue, RAM as a sparse map.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } st_t;

  typedef struct {
    bit                known;
    logic [DATA_W-1:0] data;
    int unsigned       cyc;
  } exp_t;

  st_t               sbq [$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  exp_t              expq [$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  logic        prev_rst = 1'b1;
  bit          last_known = 1'b0;
  logic [DATA_W-1:0] last_d = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_rst <= reset;
  end

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one look per cycle, away from the rising edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      check("reset_dvalid", d_valid, '0);
      check("reset_din", D_in, '0);
      last_known = 1'b1;
      last_d     = '0;
    end else if (expq.size() > 0 && expq[0].cyc == cyc - 1) begin
      e = expq.pop_front();
      check("load_dvalid", d_valid, 1);
      if (e.known) check("load_data", D_in, e.data);
      last_known = e.known;
      last_d     = e.data;
    end else begin
      check("noload_dvalid", d_valid, '0);
      if (last_known) check("hold_din", D_in, last_d);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: one request per call, model updated in the same step.
  // ---------------------------------------------------------------------------
  task automatic do_cycle(input bit st, input bit ld, input logic [15:0] a,
                          input logic [DATA_W-1:0] d, input string tag);
    bit                is_load;
    bit                is_idle;
    bit                full;
    logic [ADDR_W-1:0] wa;
    exp_t              e;
    @(negedge clk);
    reset   = 1'b0;
    mw_en   = st;
    mr_en   = ld;
    Address = a;
    Alu_Out = d;
    is_load = ld && !st;
    is_idle = !ld && !st;
    full    = (sbq.size() == SB_DEPTH);
    wa      = a[ADDR_W-1:0];
    #1;
    check({tag, ":stall"}, stall, (is_load && full) ? 1 : 0);
    check({tag, ":count"}, sb_count, sbq.size());
    check({tag, ":full"}, sb_full, full ? 1 : 0);
    if (is_load && !full) begin
      e.known = 1'b0;
      e.data  = '0;
      e.cyc   = cyc;
      if (mem.exists(wa)) begin
        e.known = 1'b1;
        e.data  = mem[wa];
      end
      foreach (sbq[i]) begin
        if (sbq[i].addr == wa) begin
          e.known = 1'b1;
          e.data  = sbq[i].data;
        end
      end
      expq.push_back(e);
    end
    if (sbq.size() > 0 && (is_idle || full)) begin
      mem[sbq[0].addr] = sbq[0].data;
      void'(sbq.pop_front());
    end
    if (st) sbq.push_back('{wa, d});
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mw_en = 1'b0;
      mr_en = 1'b0;
      sbq.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 16'h0, '0, "idle");
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d0;
    logic [15:0]       ra;
    int                kind;

    // Reset and idle
    do_reset(2);
    idle(3);

    // Store then load same address, then again from RAM after draining
    do_cycle(1, 0, 16'h000A, 128'hDEAD_BEEF, "st0A");
    do_cycle(0, 1, 16'h000A, '0, "ld0A_fwd");
    idle(3);
    do_cycle(0, 1, 16'h000A, '0, "ld0A_ram");
    idle(1);

    // Youngest-match forwarding
    do_cycle(1, 0, 16'h0005, 128'd1, "st05a");
    do_cycle(1, 0, 16'h0005, 128'd2, "st05b");
    do_cycle(1, 0, 16'h0006, 128'd3, "st06");
    do_cycle(0, 1, 16'h0005, '0, "ld05_fwd");
    idle(4);
    do_cycle(0, 1, 16'h0005, '0, "ld05_ram");
    idle(1);

    // Full with load: stall, one drain, then the held load is accepted
    for (int i = 0; i < 4; i++) do_cycle(1, 0, 16'h0010 + 16'(i), rnd_data(), "st_fill");
    do_cycle(0, 1, 16'h0010, '0, "ld10_stall");
    do_cycle(0, 1, 16'h0010, '0, "ld10_held");
    idle(4);

    // Full with store: count saturates at 4, all five values readable
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 16'h0030 + 16'(i), rnd_data(), "st_over");
    idle(5);
    for (int i = 0; i < 5; i++) do_cycle(0, 1, 16'h0030 + 16'(i), '0, "ld_over");
    idle(1);

    // Reset discards pending stores; aliasing of the upper address bits
    do_cycle(1, 0, 16'h0020, 128'hAAAA, "st20_old");
    do_cycle(1, 0, 16'h0021, 128'hBBBB, "st21_old");
    idle(3);
    do_cycle(1, 0, 16'h0020, 128'hCCCC, "st20_new");
    do_cycle(1, 0, 16'h0021, 128'hDDDD, "st21_new");
    do_reset(1);
    do_cycle(0, 1, 16'h0020, '0, "ld20_after_rst");
    do_cycle(0, 1, 16'h0021, '0, "ld21_after_rst");
    do_cycle(0, 1, 16'h0105, '0, "ld0105_alias");
    idle(1);

    // Randomised traffic over a small aliased address window
    for (int i = 0; i < 400; i++) begin
      ra      = 16'($urandom);
      ra[7:0] = 8'($urandom_range(0, 15));
      d0      = rnd_data();
      kind    = $urandom_range(0, 9);
      if (kind < 4)      do_cycle(1, kind == 0, ra, d0, "rnd_st");
      else if (kind < 8) do_cycle(0, 1, ra, '0, "rnd_ld");
      else               do_cycle(0, 0, ra, '0, "rnd_idle");
    end
    idle(8);

    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected loads never reported, required 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
